// File: rtl/spi_fifo_pkg.sv
// Shared register offsets and bit positions for the AHB SPI FIFO front-end.
package spi_fifo_pkg;

  // Register offsets, HADDR[3:2]
  localparam logic [1:0] REG_TXDATA = 2'h0;
  localparam logic [1:0] REG_RXDATA = 2'h1;
  localparam logic [1:0] REG_STATUS = 2'h2;
  localparam logic [1:0] REG_CTRL   = 2'h3;

  // STATUS bit positions
  localparam int unsigned ST_TX_EMPTY   = 0;
  localparam int unsigned ST_TX_FULL    = 1;
  localparam int unsigned ST_RX_EMPTY   = 2;
  localparam int unsigned ST_RX_FULL    = 3;
  localparam int unsigned ST_TX_OVF     = 4;
  localparam int unsigned ST_RX_OVF     = 5;
  localparam int unsigned ST_RX_UDF     = 6;
  localparam int unsigned ST_TX_LVL_LSB = 8;
  localparam int unsigned ST_RX_LVL_LSB = 16;
  localparam int unsigned LVL_FIELD_W   = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_FLUSH_TX   = 0;
  localparam int unsigned CTRL_FLUSH_RX   = 1;
  localparam int unsigned CTRL_CLR_STICKY = 2;
  localparam int unsigned CTRL_TXIE       = 8;
  localparam int unsigned CTRL_RXIE       = 9;

  localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/ahb_spi_fifo_if.sv
// AHB-Lite slave bus signals for the SPI FIFO front-end.
interface ahb_spi_fifo_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and level count.
// Contents are not reset; dout reads 0 while empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_level == '0);
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign level = r_level;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and level bookkeeping; flush overrides any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
      if (w_do_pop)  r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/ahb_spi_fifo.sv
// AHB-Lite slave front-end buffering bytes to/from the SPI byte shifter.
// Optional interrupt support is compiled in with SPI_FIFO_IRQ_EN.
module ahb_spi_fifo
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_spi_fifo_if.slave     bus,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]        r_addr;
  logic              r_write;
  logic              r_valid;
  logic              r_tx_ovf;
  logic              r_rx_ovf;
  logic              r_rx_udf;

  logic              w_dp;
  logic              w_wr_tx;
  logic              w_rd_rx;
  logic              w_wr_ctrl;
  logic              w_flush_tx;
  logic              w_flush_rx;
  logic              w_clr_sticky;
  logic              w_tx_pop;
  logic              w_rx_pop;
  logic              w_set_tx_ovf;
  logic              w_set_rx_ovf;
  logic              w_set_rx_udf;
  logic [BYTE_W-1:0] w_tx_dout;
  logic [BYTE_W-1:0] w_rx_dout;
  logic              w_tx_empty;
  logic              w_tx_full;
  logic              w_rx_empty;
  logic              w_rx_full;
  logic [AW:0]       w_tx_level;
  logic [AW:0]       w_rx_level;
  logic [1:0]        w_ie;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign bus.HREADYOUT = 1'b1;
  assign w_unused = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:8]};

  // Address-phase capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_valid <= 1'b0;
    end else if (bus.HREADY) begin
      r_valid <= bus.HSEL & bus.HTRANS[1];
      if (bus.HSEL && bus.HTRANS[1]) begin
        r_addr  <= bus.HADDR[3:2];
        r_write <= bus.HWRITE;
      end
    end
  end

  // Data-phase decode
  assign w_dp         = r_valid & bus.HREADY;
  assign w_wr_tx      = w_dp &  r_write & (r_addr == REG_TXDATA);
  assign w_rd_rx      = w_dp & ~r_write & (r_addr == REG_RXDATA);
  assign w_wr_ctrl    = w_dp &  r_write & (r_addr == REG_CTRL);
  assign w_flush_tx   = w_wr_ctrl & bus.HWDATA[CTRL_FLUSH_TX];
  assign w_flush_rx   = w_wr_ctrl & bus.HWDATA[CTRL_FLUSH_RX];
  assign w_clr_sticky = w_wr_ctrl & bus.HWDATA[CTRL_CLR_STICKY];

  assign tx_valid = ~w_tx_empty;
  assign tx_data  = w_tx_dout;
  assign w_tx_pop = tx_valid & tx_ready;
  assign w_rx_pop = w_rd_rx & ~w_rx_empty;

  // Sticky error events; a flush discards the byte without flagging overflow
  assign w_set_tx_ovf = w_wr_tx & w_tx_full & ~w_tx_pop & ~w_flush_tx;
  assign w_set_rx_ovf = rx_valid & w_rx_full & ~w_rx_pop & ~w_flush_rx;
  assign w_set_rx_udf = w_rd_rx & w_rx_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_tx_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (w_wr_tx),
    .pop   (w_tx_pop),
    .flush (w_flush_tx),
    .din   (bus.HWDATA[BYTE_W-1:0]),
    .dout  (w_tx_dout),
    .empty (w_tx_empty),
    .full  (w_tx_full),
    .level (w_tx_level)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_rx_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (rx_valid),
    .pop   (w_rx_pop),
    .flush (w_flush_rx),
    .din   (rx_data),
    .dout  (w_rx_dout),
    .empty (w_rx_empty),
    .full  (w_rx_full),
    .level (w_rx_level)
  );

  // Sticky flags; a same-cycle set wins over a clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tx_ovf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_tx_ovf <= w_set_tx_ovf | (r_tx_ovf & ~w_clr_sticky);
      r_rx_ovf <= w_set_rx_ovf | (r_rx_ovf & ~w_clr_sticky);
      r_rx_udf <= w_set_rx_udf | (r_rx_udf & ~w_clr_sticky);
    end
  end

`ifdef SPI_FIFO_IRQ_EN
  logic [1:0] r_ie;
  logic       r_irq;

  // Interrupt enables held in CTRL[9:8]
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_ie <= '0;
    else if (w_wr_ctrl) r_ie <= bus.HWDATA[CTRL_RXIE:CTRL_TXIE];
  end

  // Registered level interrupt
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_irq <= 1'b0;
    else r_irq <= (r_ie[0] & w_tx_empty) | (r_ie[1] & ~w_rx_empty) | r_tx_ovf | r_rx_ovf;
  end

  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  assign w_ie = 2'b00;
  assign irq  = 1'b0;
`endif

  // Read mux, driven from the latched address throughout the data phase
  always_comb begin
    w_rdata = '0;
    case (r_addr)
      REG_TXDATA: w_rdata[BYTE_W-1:0] = w_tx_dout;
      REG_RXDATA: w_rdata[BYTE_W-1:0] = w_rx_dout;
      REG_STATUS: begin
        w_rdata[ST_TX_EMPTY] = w_tx_empty;
        w_rdata[ST_TX_FULL]  = w_tx_full;
        w_rdata[ST_RX_EMPTY] = w_rx_empty;
        w_rdata[ST_RX_FULL]  = w_rx_full;
        w_rdata[ST_TX_OVF]   = r_tx_ovf;
        w_rdata[ST_RX_OVF]   = r_rx_ovf;
        w_rdata[ST_RX_UDF]   = r_rx_udf;
        w_rdata[ST_TX_LVL_LSB +: LVL_FIELD_W] = LVL_FIELD_W'(w_tx_level);
        w_rdata[ST_RX_LVL_LSB +: LVL_FIELD_W] = LVL_FIELD_W'(w_rx_level);
      end
      default:    w_rdata[CTRL_RXIE:CTRL_TXIE] = w_ie;
    endcase
  end

  assign bus.HRDATA = w_rdata;

endmodule

// File: doc/ahb_spi_fifo.md
Name: ahb_spi_fifo

Overview:
- AHB-Lite slave front-end that buffers bytes for the SPI byte shifter.
- Sits directly upstream of the shifter: CPU writes queue in a TX FIFO, and the shifter pulls bytes through a valid/ready handshake.
- Bytes the shifter receives return into an RX FIFO, which the CPU pops.
- Removes per-byte polling of the shifter's busy flag.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..64.
- AW, $clog2(DEPTH), pointer width; level counters are AW+1 bits.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready; address phase is sampled only when high.
- HADDR  in  32  address; only [3:2] is decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 marks a valid transfer.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, sampled in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  tied 1; no wait states.
- tx_valid  out  1  TX FIFO not empty.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  shifter idle and accepting.
- rx_valid  in  1  one-cycle pulse: shifter finished a byte.
- rx_data  in  8  received byte, qualified by rx_valid.
- irq  out  1  level interrupt; tied 0 unless SPI_FIFO_IRQ_EN.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Pointers, levels, sticky flags, CTRL and latched address/write all zero.
  - tx_valid=0, tx_data=0, irq=0.
  - FIFO contents are not reset.
- Address phase: when HREADY&HSEL&HTRANS[1], latch HADDR[3:2] and HWRITE into rAddr/rWrite and set rValid. Otherwise clear rValid when HREADY.
- Register map, decoded in the data phase with rValid=1:
  - 0x0 TXDATA. Write pushes HWDATA[7:0]. Read returns {24'b0, head}, no pop.
  - 0x4 RXDATA. Read returns {24'b0, RX head} and pops at end of the data phase. Write is ignored.
  - 0x8 STATUS (RO). Bit0 tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_ovf, [6] rx_udf, [15:8] tx_level, [23:16] rx_level; other bits 0.
  - 0xC CTRL. Write: bit0 flush TX, bit1 flush RX (self-clearing), bit2 clear all sticky flags, [9:8] IE (optional feature). Read returns {22'b0, IE, 8'b0}.
- HRDATA is combinational from rAddr and current FIFO/status state, and is valid throughout the data phase.
- TX handshake:
  - tx_valid = !tx_empty; tx_data = head, first-word-fall-through.
  - Pop on tx_valid&tx_ready.
  - tx_data holds stable while tx_valid=1 and tx_ready=0.
- TX push:
  - When full, the byte is dropped and tx_ovf is set.
  - Push and pop in the same cycle: both happen, level unchanged. This is legal even when full, because the pop frees the slot.
  - Write-to-shifter latency: a byte written to an empty FIFO drives tx_valid=1 on the cycle after the data phase.
- RX push on rx_valid:
  - When full, the byte is dropped and rx_ovf is set.
  - CPU pop and rx_valid in the same cycle: both happen.
- RXDATA read when empty: returns 0, no pointer change, rx_udf is set.
- Flush beats any same-cycle push or pop on that FIFO: level becomes 0 and the pushed byte is lost, with no ovf.
- Sticky clear (CTRL bit2) loses to a same-cycle set event: the flag stays 1.
- Pointers wrap modulo DEPTH. Level saturates logically at DEPTH (full) and never exceeds it.
- Reset asserted mid-transfer: FIFOs empty immediately and tx_valid drops asynchronously. The shifter completes or aborts on its own reset.

Optional Feature:
- SPI_FIFO_IRQ_EN defined:
  - CTRL[8] = TXIE, CTRL[9] = RXIE.
  - irq = (TXIE&tx_empty) | (RXIE&!rx_empty) | tx_ovf | rx_ovf; registered, so one cycle after the cause.
- Undefined: irq tied 0, CTRL[9:8] read 0 and writes to them are ignored.

Decomposition:
- Package spi_fifo_pkg:
  - Register offsets: TXDATA=2'h0, RXDATA=2'h1, STATUS=2'h2, CTRL=2'h3.
  - STATUS bit positions and CTRL bit positions.
- Sub-module sync_fifo (DEPTH, WIDTH=8):
  - Ports: push, pop, flush, din, dout (FWFT), empty, full, level.
  - Instanced twice, for TX and RX.
- The bus decode, sticky flags and irq live in the top.

Test Plan:
- Reset, then write 0xA5 to 0x0 with tx_ready=0 → tx_valid=1, tx_data=0xA5, STATUS[15:8]=1. Raise tx_ready for 1 cycle → tx_valid=0, tx_empty=1.
- With tx_ready=0, write 9 bytes 0x01..0x09 (DEPTH=8) → tx_full=1, tx_ovf=1. Drain order 0x01..0x08; 0x09 is never seen.
- Pulse rx_valid with 0x3C then 0x7E; read 0x4 twice → 0x3C, 0x7E. A third read → 0x0, rx_udf=1, rx_level=0.
- Full TX FIFO, same-cycle pop and TXDATA write of 0x55 → level stays 8, no ovf, 0x55 is the last byte drained.
- Three bytes queued, write CTRL=0x1 in the same data phase as an rx_valid pulse → tx_level=0, tx_valid=0 next cycle, RX receives its byte normally. Write CTRL=0x4 → STATUS[6:4]=0.
- With SPI_FIFO_IRQ_EN, CTRL=0x200, pulse rx_valid → irq=1 one cycle later. Pop RXDATA → irq=0 one cycle later. Without the macro, irq stays 0 throughout.
